// File: rtl/nios2_cpu_oci_dct_packer.sv
// Packs 2-bit direct-trace codes into frames of up to 15 codes with a one-deep output slot.
// Optional NIOS2_CPU_OCI_DCT_OVF_EN: never back-pressure in ACCUM, drop and count unstorable codes.
module nios2_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dct_code_valid,
  input  logic [1:0]  dct_code,
  output logic        dct_code_ready,
  input  logic        flush_req,
  input  logic        test_ending,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic [29:0] frm_buffer,
  output logic [3:0]  frm_count,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic        test_has_ended,
`ifdef NIOS2_CPU_OCI_DCT_OVF_EN
  output logic [7:0]  dct_ovf_cnt,
`endif
  output logic [1:0]  dbg_state
);

  // Handshakes: a code moves on dct_code_valid && dct_code_ready at the rising
  // edge; a frame moves on frm_valid && frm_ready. The slot counts as free in
  // the same cycle it is being consumed.
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FLUSH  = 2'd1,
    ENDING = 2'd2,
    ENDED  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] frm_buf_q, frm_buf_d;
  logic [3:0]  frm_cnt_q, frm_cnt_d;
  logic        frm_valid_q, frm_valid_d;

  logic slot_free;
  logic full;
  logic xfer;
  logic rdy;
  logic accept;

  always_comb begin
    slot_free = !frm_valid_q || frm_ready;
    full      = (cnt_q == 4'd15);
    state_d   = state_q;
    xfer      = 1'b0;
    rdy       = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ACCUM: begin
        xfer   = full && slot_free;
`ifdef NIOS2_CPU_OCI_DCT_OVF_EN
        rdy    = 1'b1;
`else
        rdy    = !full || slot_free;
`endif
        accept = dct_code_valid && (!full || slot_free);
        if (test_ending)
          state_d = ENDING;
        else if (flush_req && (cnt_q != 4'd0))
          state_d = FLUSH;
      end
      FLUSH: begin
        // A full frame moved out while entering FLUSH can leave nothing to flush.
        xfer = slot_free && (cnt_q != 4'd0);
        if (test_ending)
          state_d = ENDING;
        else if (slot_free || (cnt_q == 4'd0))
          state_d = ACCUM;
      end
      ENDING: begin
        xfer = slot_free && (cnt_q != 4'd0);
        if ((cnt_q == 4'd0) && !frm_valid_q)
          state_d = ENDED;
      end
      default: ;
    endcase
  end

  // A transfer empties the accumulator first so a code taken on the same edge lands as count 1.
  always_comb begin
    buf_d       = xfer ? 30'd0 : buf_q;
    cnt_d       = xfer ? 4'd0 : cnt_q;
    frm_buf_d   = frm_buf_q;
    frm_cnt_d   = frm_cnt_q;
    frm_valid_d = frm_valid_q;
    if (accept) begin
      buf_d = {buf_d[27:0], dct_code};
      cnt_d = cnt_d + 4'd1;
    end
    if (xfer) begin
      frm_buf_d   = buf_q;
      frm_cnt_d   = cnt_q;
      frm_valid_d = 1'b1;
    end else if (frm_valid_q && frm_ready) begin
      frm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      buf_q       <= 30'd0;
      cnt_q       <= 4'd0;
      frm_buf_q   <= 30'd0;
      frm_cnt_q   <= 4'd0;
      frm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      frm_buf_q   <= frm_buf_d;
      frm_cnt_q   <= frm_cnt_d;
      frm_valid_q <= frm_valid_d;
    end
  end

`ifdef NIOS2_CPU_OCI_DCT_OVF_EN
  logic [7:0] ovf_q;
  logic       drop;

  assign drop = dct_code_valid && !accept && (state_q != ENDED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_q <= 8'd0;
    else if (drop && (ovf_q != 8'hFF))
      ovf_q <= ovf_q + 8'd1;
  end

  assign dct_ovf_cnt = ovf_q;
`endif

  // Ready is masked while reset is held so every output reads 0 during reset.
  assign dct_code_ready = rdy && reset_n;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign frm_buffer     = frm_buf_q;
  assign frm_count      = frm_cnt_q;
  assign frm_valid      = frm_valid_q;
  assign test_has_ended = (state_q == ENDED);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_nios2_cpu_oci_dct_packer.sv
// Bench for nios2_cpu_oci_dct_packer: directed scenarios plus random traffic, with a
// frame scoreboard fed by a code-list reference model.
module tb_nios2_cpu_oci_dct_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        dct_code_valid;
  logic [1:0]  dct_code;
  logic        dct_code_ready;
  logic        flush_req;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [29:0] frm_buffer;
  logic [3:0]  frm_count;
  logic        frm_valid;
  logic        frm_ready;
  logic        test_has_ended;
  logic [1:0]  dbg_state;
`ifdef NIOS2_CPU_OCI_DCT_OVF_EN
  logic [7:0]  dct_ovf_cnt;
`endif

  nios2_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_code_valid (dct_code_valid),
    .dct_code       (dct_code),
    .dct_code_ready (dct_code_ready),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .frm_buffer     (frm_buffer),
    .frm_count      (frm_count),
    .frm_valid      (frm_valid),
    .frm_ready      (frm_ready),
    .test_has_ended (test_has_ended),
`ifdef NIOS2_CPU_OCI_DCT_OVF_EN
    .dct_ovf_cnt    (dct_ovf_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // A frame is the ordered list of codes accepted since the previous frame:
  // closed at 15 codes, or early by a flush / end request when non-empty.
  logic [1:0]  pend[$];
  logic [33:0] exp_q[$];

  function automatic void push_frame();
    logic [29:0] b;
    b = 30'd0;
    foreach (pend[i]) b = b * 30'd4 + 30'(pend[i]);
    exp_q.push_back({4'(pend.size()), b});
    pend.delete();
  endfunction

  always @(negedge clk) begin
    logic acc;
    if (!reset_n) begin
      pend.delete();
      exp_q.delete();
    end else begin
      acc = dct_code_valid && dct_code_ready;
`ifdef NIOS2_CPU_OCI_DCT_OVF_EN
      acc = acc && !(dct_count == 4'd15 && frm_valid && !frm_ready);
`endif
      if (acc) begin
        pend.push_back(dct_code);
        if (pend.size() == 15) push_frame();
      end
      if ((flush_req || test_ending) && !test_has_ended && pend.size() != 0)
        push_frame();
    end
  end

  // Monitor: every consumed frame is compared with the oldest expected one.
  always @(negedge clk) begin
    logic [33:0] e;
    if (reset_n && frm_valid && frm_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_unexpected: got count %0d data 0x%0h, none expected", frm_count, frm_buffer);
      end else begin
        e = exp_q.pop_front();
        check("frame_count", 32'(frm_count), 32'(e[33:30]));
        check("frame_data", 32'(frm_buffer), 32'(e[29:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [1:0] c);
    dct_code_valid = 1'b1;
    dct_code       = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dct_code_ready) begin
        tick();
        dct_code_valid = 1'b0;
        return;
      end
      tick();
    end
    dct_code_valid = 1'b0;
    timeout_fail("send_code");
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic pulse_ending();
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
  endtask

  task automatic wait_frm(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frm_valid) return;
      tick();
    end
    timeout_fail(name);
  endtask

  task automatic wait_ended(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (test_has_ended) return;
      tick();
    end
    timeout_fail(name);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    logic [1:0] c31;
    reset_n        = 1'b0;
    dct_code_valid = 1'b0;
    dct_code       = 2'd0;
    flush_req      = 1'b0;
    test_ending    = 1'b0;
    frm_ready      = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_dct_count", 32'(dct_count), 32'd0);
    check("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    check("rst_frm_valid", 32'(frm_valid), 32'd0);
    check("rst_frm_count", 32'(frm_count), 32'd0);
    check("rst_ended", 32'(test_has_ended), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after_release", 32'(dct_code_ready), 32'd1);
    tick();

    // Full frame of fifteen 2'b01 codes.
    frm_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_code(2'b01);
    @(negedge clk);
    check("full_count_15", 32'(dct_count), 32'd15);
    tick();
    @(negedge clk);
    check("full_frm_valid", 32'(frm_valid), 32'd1);
    check("full_frm_buffer", 32'(frm_buffer), 32'h1555_5555);
    check("full_frm_count", 32'(frm_count), 32'd15);
    check("full_dct_count_0", 32'(dct_count), 32'd0);
    tick();

    // Partial flush of 3,2,1 then an empty flush.
    send_code(2'd3);
    send_code(2'd2);
    send_code(2'd1);
    pulse_flush();
    wait_frm("flush_frame");
    check("flush_frm_buffer", 32'(frm_buffer), 32'h39);
    check("flush_frm_count", 32'(frm_count), 32'd3);
    tick();
    pulse_flush();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frm_valid) seen = 1'b1;
      tick();
    end
    check("flush_empty_no_frame", 32'(seen), 32'd0);

`ifndef NIOS2_CPU_OCI_DCT_OVF_EN
    // Back-pressure: 31 codes with the consumer stalled.
    frm_ready = 1'b0;
    for (int i = 0; i < 30; i++) send_code(2'($urandom_range(0, 3)));
    c31 = 2'($urandom_range(0, 3));
    dct_code_valid = 1'b1;
    dct_code       = c31;
    @(negedge clk);
    check("bp_count_15", 32'(dct_count), 32'd15);
    check("bp_ready_low", 32'(dct_code_ready), 32'd0);
    check("bp_frm_valid", 32'(frm_valid), 32'd1);
    tick();
    frm_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_on_free", 32'(dct_code_ready), 32'd1);
    tick();
    dct_code_valid = 1'b0;
    @(negedge clk);
    check("bp_31st_count_1", 32'(dct_count), 32'd1);
    check("bp_31st_data", 32'(dct_buffer), 32'(c31));
    check("bp_frame2_count", 32'(frm_count), 32'd15);
    tick();
`else
    // Overflow counting: stall with a full accumulator and a busy slot.
    do_reset();
    frm_ready = 1'b0;
    for (int i = 0; i < 30; i++) send_code(2'($urandom_range(0, 3)));
    dct_code_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    dct_code_valid = 1'b0;
    @(negedge clk);
    check("ovf_saturated", 32'(dct_ovf_cnt), 32'd255);
    check("ovf_count_kept", 32'(dct_count), 32'd15);
    tick();
    frm_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
`endif

    // End of trace with a busy slot and five pending codes.
    do_reset();
    frm_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_code(2'($urandom_range(0, 3)));
    @(negedge clk);
    check("end_count_5", 32'(dct_count), 32'd5);
    check("end_slot_busy", 32'(frm_valid), 32'd1);
    tick();
    pulse_ending();
    dct_code_valid = 1'b1;
    @(negedge clk);
    check("end_ready_low", 32'(dct_code_ready), 32'd0);
    tick();
    tick();
    @(negedge clk);
    check("end_not_yet", 32'(test_has_ended), 32'd0);
    tick();
    dct_code_valid = 1'b0;
    frm_ready = 1'b1;
    wait_ended("end_wait");
    check("end_ended", 32'(test_has_ended), 32'd1);
    check("end_drained", 32'(exp_q.size()), 32'd0);
    tick();
    dct_code_valid = 1'b1;
    flush_req      = 1'b1;
    test_ending    = 1'b1;
    tick();
    tick();
    dct_code_valid = 1'b0;
    flush_req      = 1'b0;
    test_ending    = 1'b0;
    @(negedge clk);
    check("end_sticky", 32'(test_has_ended), 32'd1);
    check("end_ignore_codes", 32'(dct_count), 32'd0);
    check("end_ready_stays_low", 32'(dct_code_ready), 32'd0);
    tick();

    // Asynchronous reset in the middle of ENDING with count 7.
    do_reset();
    frm_ready = 1'b0;
    for (int i = 0; i < 22; i++) send_code(2'($urandom_range(0, 3)));
    pulse_ending();
    tick();
    @(negedge clk);
    check("mid_end_count_7", 32'(dct_count), 32'd7);
    #2 reset_n = 1'b0;
    #1;
    check("async_dct_count", 32'(dct_count), 32'd0);
    check("async_dct_buffer", 32'(dct_buffer), 32'd0);
    check("async_frm_valid", 32'(frm_valid), 32'd0);
    check("async_frm_count", 32'(frm_count), 32'd0);
    check("async_frm_buffer", 32'(frm_buffer), 32'd0);
    check("async_ended", 32'(test_has_ended), 32'd0);
    check("async_ready", 32'(dct_code_ready), 32'd0);
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("async_ready_after", 32'(dct_code_ready), 32'd1);
    tick();

    // Random traffic with random consumer stalls and flushes.
    for (int i = 0; i < 600; i++) begin
      frm_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        flush_req      = 1'b1;
        dct_code_valid = 1'b0;
      end else begin
        flush_req      = 1'b0;
        dct_code_valid = 1'($urandom_range(0, 1));
        dct_code       = 2'($urandom_range(0, 3));
      end
      tick();
    end
    dct_code_valid = 1'b0;
    flush_req      = 1'b0;
    frm_ready      = 1'b1;
    pulse_ending();
    wait_ended("rand_end_wait");
    check("rand_ended", 32'(test_has_ended), 32'd1);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_cpu_oci_dct_packer.md
NIOS2_CPU_OCI_DCT_PACKER -- requirements
Module: nios2_cpu_oci_dct_packer

Interface
REQ-001 Clocking SHALL be one clock, `clk`; reset SHALL be `reset_n`, asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 dct_code_valid  input  1  direct-trace code offered this cycle.
REQ-005 dct_code  input  2  direct-trace code value.
REQ-006 dct_code_ready  output  1  code accepted when valid&&ready at the clock edge.
REQ-007 flush_req  input  1  single-cycle request to emit the partial buffer.
REQ-008 test_ending  input  1  end-of-trace request; sampled every cycle.
REQ-009 dct_buffer  output  30  live accumulation buffer, newest code in [1:0].
REQ-010 dct_count  output  4  live number of codes in dct_buffer (0..15).
REQ-011 frm_buffer  output  30  emitted frame data.
REQ-012 frm_count  output  4  emitted frame code count (1..15, never 0).
REQ-013 frm_valid  output  1  frame slot occupied.
REQ-014 frm_ready  input  1  consumer takes the frame when frm_valid&&frm_ready.
REQ-015 test_has_ended  output  1  final frame delivered; sticky until reset.

Function
REQ-016 Accept: dct_buffer <= {dct_buffer[27:0], dct_code}; dct_count <= dct_count+1.
REQ-017 Slot free condition: !frm_valid || frm_ready in the same cycle.
REQ-018 FSM states SHALL be ACCUM, FLUSH, ENDING and ENDED.
REQ-019 ACCUM: dct_code_ready = (dct_count<15) || slot free.
REQ-020 ACCUM, dct_count==15 and slot free: frm_* <= buffer/count, frm_valid <= 1.
REQ-021 In that same edge, the buffer SHALL clear; a code accepted in that edge SHALL land as count 1 in the cleared buffer.
REQ-022 A frame SHALL appear on frm_* the cycle after its transfer edge (latency 1).
REQ-023 Consumption without a new transfer in the same edge SHALL clear frm_valid; consumption plus transfer in the same edge SHALL keep frm_valid=1 with the new frame.
REQ-024 Partial frames SHALL hold codes in bits [2*count-1:0] with upper bits zero.
REQ-025 flush_req in ACCUM with count>0 SHALL enter FLUSH; with count==0 it SHALL be a no-op.
REQ-026 FLUSH: dct_code_ready=0; when the slot is free, the partial frame SHALL transfer and the FSM SHALL return to ACCUM.
REQ-027 test_ending SHALL take priority over flush_req; in ACCUM or FLUSH it SHALL enter ENDING.
REQ-028 ENDING: dct_code_ready=0; partial frame (if count>0) SHALL transfer when the slot is free; enter ENDED once count==0 and frm_valid==0.
REQ-029 ENDED: test_has_ended=1; dct_code_ready=0; codes, flush_req and test_ending SHALL be ignored until reset.
REQ-030 dct_count SHALL never exceed 15 or wrap.

Reset
REQ-031 reset_n low SHALL immediately force state ACCUM, all buffers and counts 0, frm_valid 0 and test_has_ended 0, including mid-frame and mid-ENDING.
REQ-032 dct_code_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-033 Macro NIOS2_CPU_OCI_DCT_OVF_EN, when defined, SHALL add output dct_ovf_cnt (8 bits).
REQ-034 With the macro defined, dct_code_ready SHALL be 1 in ACCUM.
REQ-035 With the macro defined, a code arriving when it cannot be stored (count==15, slot busy; or FLUSH/ENDING) SHALL be dropped and dct_ovf_cnt SHALL increment, saturating at 255, reset 0.
REQ-036 Without the macro, there SHALL be no dct_ovf_cnt port, back-pressure SHALL follow REQ-019, and no code SHALL ever be lost.

Verification
REQ-037 15 codes of 2'b01 with frm_ready=1: frm_buffer=30'h15555555, frm_count=15 one cycle after the 15th accept; dct_count=0.
REQ-038 Codes 3,2,1 then flush_req: frm_buffer=30'h39, frm_count=3; flush with count 0 emits nothing.
REQ-039 frm_ready=0, 31 codes offered: 2nd frame full, dct_code_ready=0 at count 15; raising frm_ready accepts the 31st code as count 1.
REQ-040 Count 5, frm_valid held with frm_ready=0, test_ending pulse: no ready; both frames drain after frm_ready=1, then test_has_ended=1 and stays 1.
REQ-041 reset_n pulsed low mid-ENDING with count 7: all outputs 0 immediately, ready=1 after release.
REQ-042 With NIOS2_CPU_OCI_DCT_OVF_EN defined: 300 codes offered while stalled give dct_ovf_cnt=255.
